// File: rtl/x3q_dma_engine.sv
// x3q_dma_engine
//   Memory-to-memory block-copy engine for the x3q core family. Reads up to
//   FIFO_DEPTH words into an internal burst buffer, then writes them out, until
//   LENGTH words have been copied. Talks to memory through the core's single
//   port protocol: one-cycle request pulse, request_type/address/data held
//   until the matching memory_ready / write_complete.
//
//   Optional feature: define X3Q_DMA_FILL_EN to add fill mode (write a latched
//   fill word LENGTH times, no reads). Without it, fill_mode_i/fill_value_i are
//   ignored and no fill logic is built.
//
// Ports
//   clk_i               rising-edge clock
//   reset_i             synchronous, active-low reset
//   start_i             one-cycle launch, sampled only in IDLE
//   src_addr_i          first source address (latched on start)
//   dst_addr_i          first destination address (latched on start)
//   length_i            number of words to copy (latched on start)
//   fill_mode_i         1 = fill instead of copy (fill builds only)
//   fill_value_i        fill word (fill builds only)
//   busy_o              transfer in progress
//   done_o              one-cycle completion pulse
//   words_done_o        words written so far in the current transfer
//   request_o           one-cycle memory request pulse
//   request_type_o      0 read, 1 write
//   request_address_o   memory address of current request
//   data_out_o          write data
//   memory_in_i         read data, valid with memory_ready_i
//   memory_ready_i      read data valid
//   write_complete_i    write accepted
module x3q_dma_engine #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic              fill_mode_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic              request_o,
  output logic              request_type_o,
  output logic [ADDR_W-1:0] request_address_o,
  output logic [DATA_W-1:0] data_out_o,
  input  logic [DATA_W-1:0] memory_in_i,
  input  logic              memory_ready_i,
  input  logic              write_complete_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, rd_cnt_q, words_done_q;
  logic              busy_q, done_q, request_q, request_type_q;
  logic [ADDR_W-1:0] request_address_q;
  logic [DATA_W-1:0] data_out_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

`ifdef X3Q_DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_value_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_mode_i, fill_value_i};
`endif

  logic              push_d;
  logic [DATA_W-1:0] head_d;
  logic [ADDR_W-1:0] src_inc_d, dst_inc_d;
  logic [LEN_W-1:0]  rd_inc_d, words_inc_d;

  assign push_d      = reset_i && (state_q == S_RD_WAIT) && memory_ready_i;
  // With an empty buffer the word arriving this cycle is the head, so the
  // write that follows a single-word read burst takes it straight from the bus.
  assign head_d      = (count_q == '0) ? memory_in_i : fifo_mem[rd_ptr_q];
  assign src_inc_d   = src_q + ADDR_W'(1);
  assign dst_inc_d   = dst_q + ADDR_W'(1);
  assign rd_inc_d    = rd_cnt_q + LEN_W'(1);
  assign words_inc_d = words_done_q + LEN_W'(1);

  // Buffer storage carries no reset; the pointers/count define its contents.
  always_ff @(posedge clk_i) begin
    if (push_d) begin
      fifo_mem[wr_ptr_q] <= memory_in_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q           <= S_IDLE;
      src_q             <= '0;
      dst_q             <= '0;
      len_q             <= '0;
      rd_cnt_q          <= '0;
      words_done_q      <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      request_q         <= 1'b0;
      request_type_q    <= 1'b0;
      request_address_q <= '0;
      data_out_q        <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
`ifdef X3Q_DMA_FILL_EN
      fill_q            <= 1'b0;
      fill_value_q      <= '0;
`endif
    end else begin
      // Outputs are registered: a request is raised on the edge that enters
      // an ISSUE state so the pulse coincides with that state's cycle.
      done_q    <= 1'b0;
      request_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_q        <= src_addr_i;
            dst_q        <= dst_addr_i;
            len_q        <= length_i;
            rd_cnt_q     <= '0;
            words_done_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
`ifdef X3Q_DMA_FILL_EN
            fill_q       <= fill_mode_i;
            fill_value_q <= fill_value_i;
`endif
            if (length_i == '0) begin
              state_q        <= S_DONE;
              done_q         <= 1'b1;
              busy_q         <= 1'b0;
              request_type_q <= 1'b0;
              data_out_q     <= '0;
            end
`ifdef X3Q_DMA_FILL_EN
            else if (fill_mode_i) begin
              state_q           <= S_WR_ISSUE;
              busy_q            <= 1'b1;
              request_q         <= 1'b1;
              request_type_q    <= 1'b1;
              request_address_q <= dst_addr_i;
              data_out_q        <= fill_value_i;
            end
`endif
            else begin
              state_q           <= S_RD_ISSUE;
              busy_q            <= 1'b1;
              request_q         <= 1'b1;
              request_type_q    <= 1'b0;
              request_address_q <= src_addr_i;
            end
          end
        end
        S_RD_ISSUE: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (memory_ready_i) begin
            src_q    <= src_inc_d;
            rd_cnt_q <= rd_inc_d;
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if ((count_q < CNT_W'(FIFO_DEPTH - 1)) && (rd_inc_d < len_q)) begin
              state_q           <= S_RD_ISSUE;
              count_q           <= count_q + CNT_W'(1);
              request_q         <= 1'b1;
              request_type_q    <= 1'b0;
              request_address_q <= src_inc_d;
            end else begin
              // Push and pop on the same edge: occupancy is unchanged.
              state_q           <= S_WR_ISSUE;
              rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
              request_q         <= 1'b1;
              request_type_q    <= 1'b1;
              request_address_q <= dst_q;
              data_out_q        <= head_d;
            end
          end
        end
        S_WR_ISSUE: state_q <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (write_complete_i) begin
            dst_q        <= dst_inc_d;
            words_done_q <= words_inc_d;
            if (words_inc_d == len_q) begin
              state_q        <= S_DONE;
              done_q         <= 1'b1;
              busy_q         <= 1'b0;
              request_type_q <= 1'b0;
              data_out_q     <= '0;
            end
`ifdef X3Q_DMA_FILL_EN
            else if (fill_q) begin
              state_q           <= S_WR_ISSUE;
              request_q         <= 1'b1;
              request_type_q    <= 1'b1;
              request_address_q <= dst_inc_d;
              data_out_q        <= fill_value_q;
            end
`endif
            else if (count_q != '0) begin
              state_q           <= S_WR_ISSUE;
              rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
              count_q           <= count_q - CNT_W'(1);
              request_q         <= 1'b1;
              request_type_q    <= 1'b1;
              request_address_q <= dst_inc_d;
              data_out_q        <= head_d;
            end else begin
              state_q           <= S_RD_ISSUE;
              request_q         <= 1'b1;
              request_type_q    <= 1'b0;
              request_address_q <= src_q;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign words_done_o      = words_done_q;
  assign request_o         = request_q;
  assign request_type_o    = request_type_q;
  assign request_address_o = request_address_q;
  assign data_out_o        = data_out_q;

endmodule
